// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Byte FIFO in front of an 8N1 UART transmitter (LSB first, line idles high).
//   Bytes written while the FIFO is full are dropped and flagged on overflow.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   data      byte offered by the upstream printer
//   new_data  one-cycle strobe qualifying data
//   busy      FIFO full; upstream must hold off new_data
//   block     inhibits starting a new frame (a frame in progress completes)
//   tx        registered serial output
//   level     number of bytes currently buffered
//   overflow  one-cycle pulse after a byte was dropped
module uart_tx_buffered #(
  parameter int CLK_PER_BIT = 50,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data,
  input  logic                         new_data,
  output logic                         busy,
  input  logic                         block,
  output logic                         tx,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [AW:0]   FULL_LVL = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shreg;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          wr_en, pop, bit_end, tx_n;

  // busy looks only at the registered level, so a pop on the same edge
  // never makes room for a write that arrives while full.
  assign busy    = (level == FULL_LVL);
  assign wr_en   = new_data && !busy && !rst;
  assign bit_end = (cnt == CNT_MAX);

  // FIFO storage has no reset; only the pointers and level do.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data;
    if (pop)   shreg <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= new_data && busy;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Serializer state register, bit-period counter and bit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      if (state == IDLE || bit_end) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (bit_end)   bit_idx <= bit_idx + 3'd1;
    end
  end

  // tx is registered from the current state, which puts the line one cycle
  // behind the state register: write edge -> pop edge -> first start cycle.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (level != '0 && !block) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg[bit_idx];
        if (bit_end && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (level != '0 && !block) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLK_PER_BIT=4, FIFO_DEPTH=16.
// Outputs are sampled 1 ns after each rising edge; inputs change right after.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       new_data = 1'b0;
  logic       busy;
  logic       block = 1'b0;
  logic       tx;
  logic [4:0] level;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  int ovf_seen = 0;
  int bad_cnt;

  uart_tx_buffered #(.CLK_PER_BIT(4), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .data(data), .new_data(new_data), .busy(busy),
    .block(block), .tx(tx), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] val(input int k);
    return 8'(k * 37 + 5);
  endfunction

  // Checks 40 consecutive tx samples of one frame, starting with the current
  // sample (the first start-bit cycle). Optionally raises block at cycle
  // block_at and writes one byte during cycle 0.
  task automatic check_frame(input logic [7:0] b, input int block_at,
                             input logic do_wr, input logic [7:0] wv);
    logic exp;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      if (i == 1) new_data = 1'b0;
      if (i < 4)       exp = 1'b0;
      else if (i < 36) exp = b[3'((i - 4) / 4)];
      else             exp = 1'b1;
      chk($sformatf("frame_%02h_c%0d", b, i), 32'(tx), 32'(exp));
      if (overflow) ovf_seen++;
      if (i == block_at) block = 1'b1;
      if (i == 0 && do_wr) begin
        data = wv;
        new_data = 1'b1;
      end
    end
  endtask

  initial begin
    // Reset, with new_data asserted during reset to show it is ignored.
    data = 8'h99; new_data = 1'b1;
    step(); step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    new_data = 1'b0; rst = 1'b0;
    step();
    chk("post_rst_level", 32'(level), 32'd0);

    // Single byte 0x41 with 2-cycle latency.
    data = 8'h41; new_data = 1'b1;
    step();
    new_data = 1'b0;
    chk("single_level1", 32'(level), 32'd1);
    chk("single_tx_n0", 32'(tx), 32'd1);
    step();
    chk("single_level0", 32'(level), 32'd0);
    chk("single_tx_n1", 32'(tx), 32'd1);
    step();
    check_frame(8'h41, -1, 1'b0, 8'h00);
    step();
    chk("single_idle_tx", 32'(tx), 32'd1);
    chk("single_idle_level", 32'(level), 32'd0);

    // Back-to-back 0x55, 0xAA.
    data = 8'h55; new_data = 1'b1;
    step();
    chk("b2b_level_a", 32'(level), 32'd1);
    data = 8'hAA;
    step();
    new_data = 1'b0;
    chk("b2b_level_b", 32'(level), 32'd1);
    step();
    check_frame(8'h55, -1, 1'b0, 8'h00);
    step();
    check_frame(8'hAA, -1, 1'b0, 8'h00);
    step();
    chk("b2b_idle_tx", 32'(tx), 32'd1);
    chk("b2b_idle_level", 32'(level), 32'd0);

    // Fill to full with block=1, then overflow on the 17th byte.
    block = 1'b1;
    for (int k = 0; k < 16; k++) begin
      data = 8'(k); new_data = 1'b1;
      chk($sformatf("fill_busy_pre%0d", k), 32'(busy), 32'd0);
      step();
      chk($sformatf("fill_level%0d", k), 32'(level), 32'(k + 1));
    end
    chk("full_busy", 32'(busy), 32'd1);
    data = 8'h10;
    step();
    new_data = 1'b0;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_busy", 32'(busy), 32'd1);
    chk("ovf_tx", 32'(tx), 32'd1);
    step();
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    chk("ovf_level_hold", 32'(level), 32'd16);
    block = 1'b0;
    step();
    chk("drain_level", 32'(level), 32'd15);
    chk("drain_tx_pre", 32'(tx), 32'd1);
    step();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      check_frame(8'(k), -1, 1'b0, 8'h00);
    end
    step();
    chk("drain_idle_tx", 32'(tx), 32'd1);
    chk("drain_idle_level", 32'(level), 32'd0);

    // Block raised mid-frame with two bytes queued.
    data = 8'h3C; new_data = 1'b1;
    step();
    data = 8'hC3;
    step();
    new_data = 1'b0;
    step();
    check_frame(8'h3C, 12, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("blk_tx_hold%0d", k), 32'(tx), 32'd1);
      chk($sformatf("blk_level%0d", k), 32'(level), 32'd1);
    end
    block = 1'b0;
    step();
    chk("blk_release_tx", 32'(tx), 32'd1);
    step();
    check_frame(8'hC3, -1, 1'b0, 8'h00);
    step();
    chk("blk_idle_tx", 32'(tx), 32'd1);
    chk("blk_idle_level", 32'(level), 32'd0);

    // Reset mid-frame with three bytes queued.
    data = 8'h11; new_data = 1'b1;
    step();
    data = 8'h22;
    step();
    data = 8'h33;
    step();
    new_data = 1'b0;
    chk("rmf_level", 32'(level), 32'd2);
    for (int k = 0; k < 12; k++) step();
    rst = 1'b1;
    step();
    chk("rmf_tx", 32'(tx), 32'd1);
    chk("rmf_level0", 32'(level), 32'd0);
    chk("rmf_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    bad_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tx !== 1'b1 || level !== 5'd0) bad_cnt++;
    end
    chk("rmf_quiet", 32'(bad_cnt), 32'd0);

    // Pointer wrap: 40 bytes streamed, level never above 8.
    ovf_seen = 0;
    block = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data = val(k); new_data = 1'b1;
      step();
    end
    new_data = 1'b0;
    chk("wrap_prefill", 32'(level), 32'd8);
    block = 1'b0;
    step();
    step();
    for (int f = 0; f < 40; f++) begin
      if (f > 0) step();
      check_frame(val(f), -1, (f + 8 < 40), val(f + 8));
    end
    chk("wrap_no_overflow", 32'(ovf_seen), 32'd0);
    step();
    chk("wrap_idle_tx", 32'(tx), 32'd1);
    chk("wrap_idle_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
